// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet type and the grant-merge FSM state encoding.
package noc_pkg;

    localparam int PKT_W = 33;

    typedef logic [PKT_W-1:0] pkt_t;

    typedef enum logic {
        GM_IDLE,
        GM_WAIT_DATA
    } gm_state_t;

endpackage : noc_pkg

// File: rtl/gm_fifo.sv
// Small synchronous FIFO buffering merged packets toward the router port.
// Push and pop in the same cycle are both honoured; the head is presented
// combinationally from storage and forced to zero while the FIFO is empty.
module gm_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_en;
    logic             pop_en;

    // A push is dropped if the FIFO is full; the parent never offers one then.
    assign full      = (count == CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push_en   = push && !full;
    assign pop_en    = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // Packet storage written on push.
    // NOTE: storage has no reset; out_data is masked while empty, so stale
    // entries are never visible and the array can map onto plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : gm_fifo

// File: rtl/grant_merge.sv
// Grant-driven merge stage: accepts one grant from the arbiter, then forwards
// exactly one packet from the granted input into the output FIFO. The input
// that is not granted is back-pressured, so packets never interleave.
// All ready outputs are decoded from registered state only.
module grant_merge
    import noc_pkg::*;
#(
    parameter int WIDTH = PKT_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel_valid,
    output logic             sel_ready,
    input  logic             sel_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    gm_state_t        state;
    logic             grant;
    logic             fifo_full;
    logic             in_fire;
    logic [WIDTH-1:0] push_data;

    // Ready decode from state, latched grant and FIFO occupancy only.
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        sel_ready = 1'b0;
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        if (state == GM_IDLE) begin
            sel_ready = 1'b1;
        end else begin
            in0_ready = !grant && !fifo_full;
            in1_ready =  grant && !fifo_full;
        end
    end

    assign in_fire   = grant ? (in1_valid && in1_ready) : (in0_valid && in0_ready);
    assign push_data = grant ? in1_data : in0_data;

    // Grant/data handshake FSM: IDLE takes a grant, WAIT_DATA takes one packet.
    // NOTE: non-blocking assignments keep every register updating from the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= GM_IDLE;
            grant <= 1'b0;
        end else begin
            case (state)
                GM_IDLE: begin
                    if (sel_valid) begin
                        grant <= sel_data;
                        state <= GM_WAIT_DATA;
                    end
                end
                GM_WAIT_DATA: begin
                    if (in_fire) begin
                        state <= GM_IDLE;
                    end
                end
                default: state <= GM_IDLE;
            endcase
        end
    end

    gm_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_fire),
        .push_data (push_data),
        .full      (fifo_full),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

endmodule : grant_merge

// File: tb/tb_grant_merge.sv
// Directed bench for grant_merge with an expected-packet queue checked at the
// output port on every falling edge.
module tb_grant_merge;
    import noc_pkg::*;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel_valid, sel_ready, sel_data;
    logic       in0_valid, in0_ready;
    logic       in1_valid, in1_ready;
    pkt_t       in0_data, in1_data, out_data;
    logic       out_valid, out_ready;

    int         n_checks = 0;
    int         n_fail   = 0;
    pkt_t       exp_q[$];
    bit         hit_full  = 1'b0;
    bit         hit_empty = 1'b0;
    bit         rand_ready = 1'b0;
    bit         lo_phase   = 1'b0;

    grant_merge #(.WIDTH(PKT_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .sel_data  (sel_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input pkt_t obs, input pkt_t exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; optionally re-randomise out_ready.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) begin
            out_ready = lo_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wait_sel_ready();
        int b = 0;
        while (!sel_ready && b < 100) begin
            tick();
            b++;
        end
        check_bit("wait_sel_ready", sel_ready, 1'b1);
    endtask

    task automatic wait_in_ready(input logic g);
        int b = 0;
        while (!(g ? in1_ready : in0_ready) && b < 100) begin
            tick();
            b++;
        end
        check_bit("wait_in_ready", g ? in1_ready : in0_ready, 1'b1);
    endtask

    // One grant followed by one packet on the granted input. The other input
    // offers junk throughout the data phase and must never be taken.
    task automatic send(input logic g, input pkt_t d, input int gap);
        sel_valid = 1'b1;
        sel_data  = g;
        wait_sel_ready();
        tick();
        sel_valid = 1'b0;
        sel_data  = 1'b0;
        if (g) begin
            in0_valid = 1'b1;
            in0_data  = ~d;
        end else begin
            in1_valid = 1'b1;
            in1_data  = ~d;
        end
        repeat (gap) tick();
        if (g) begin
            in1_valid = 1'b1;
            in1_data  = d;
        end else begin
            in0_valid = 1'b1;
            in0_data  = d;
        end
        wait_in_ready(g);
        tick();
        exp_q.push_back(d);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 200) begin
            tick();
            b++;
        end
        check_bit("drain_empty", exp_q.size() == 0, 1'b1);
    endtask

    // Output monitor: queue size mirrors FIFO occupancy at each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                check_bit("out_valid_vs_model", out_valid, exp_q.size() != 0);
                if (exp_q.size() == 0)     hit_empty = 1'b1;
                if (exp_q.size() == DEPTH) hit_full  = 1'b1;
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    check("out_data_order", out_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        sel_valid = 1'b0;
        sel_data  = 1'b0;
        in0_valid = 1'b0;
        in0_data  = '0;
        in1_valid = 1'b0;
        in1_data  = '0;
        out_ready = 1'b0;

        // 1. Reset values while held, then three idle cycles after release.
        #1;
        check_bit("rst_sel_ready", sel_ready, 1'b1);
        check_bit("rst_in0_ready", in0_ready, 1'b0);
        check_bit("rst_in1_ready", in1_ready, 1'b0);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, '0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_bit("idle_sel_ready", sel_ready, 1'b1);
            check_bit("idle_in0_ready", in0_ready, 1'b0);
            check_bit("idle_in1_ready", in1_ready, 1'b0);
            check_bit("idle_out_valid", out_valid, 1'b0);
        end

        // 2. Grant 0 with both inputs valid: only in0's packet is taken.
        out_ready = 1'b1;
        sel_valid = 1'b1;
        sel_data  = 1'b0;
        in0_valid = 1'b1;
        in0_data  = 33'h1;
        in1_valid = 1'b1;
        in1_data  = 33'h2;
        tick();
        sel_valid = 1'b0;
        check_bit("g0_sel_ready", sel_ready, 1'b0);
        check_bit("g0_in0_ready", in0_ready, 1'b1);
        check_bit("g0_in1_ready", in1_ready, 1'b0);
        tick();
        exp_q.push_back(33'h1);
        in0_valid = 1'b0;
        check_bit("g0_out_valid", out_valid, 1'b1);
        check("g0_out_data", out_data, 33'h1);
        check_bit("g0_in1_ready_after", in1_ready, 1'b0);
        check_bit("g0_sel_ready_back", sel_ready, 1'b1);
        tick();
        check_bit("g0_in1_ready_idle", in1_ready, 1'b0);
        check_bit("g0_out_drained", out_valid, 1'b0);
        in1_valid = 1'b0;

        // 3. Grant 1 with the packet arriving five cycles late.
        sel_valid = 1'b1;
        sel_data  = 1'b1;
        tick();
        sel_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_bit("g1_wait_sel_ready", sel_ready, 1'b0);
            check_bit("g1_wait_in1_ready", in1_ready, 1'b1);
            check_bit("g1_wait_in0_ready", in0_ready, 1'b0);
            tick();
        end
        in1_valid = 1'b1;
        in1_data  = 33'h2;
        tick();
        exp_q.push_back(33'h2);
        in1_valid = 1'b0;
        check_bit("g1_out_valid", out_valid, 1'b1);
        check("g1_out_data", out_data, 33'h2);
        tick();
        check_bit("g1_out_drained", out_valid, 1'b0);

        // 4. Downstream stalled: A and B fill the FIFO, C is held off until space frees.
        out_ready = 1'b0;
        send(1'b0, 33'hA, 0);
        send(1'b1, 33'hB, 0);
        check_bit("full_out_valid", out_valid, 1'b1);
        check("full_head", out_data, 33'hA);
        sel_valid = 1'b1;
        sel_data  = 1'b0;
        check_bit("full_sel_ready", sel_ready, 1'b1);
        tick();
        sel_valid = 1'b0;
        in0_valid = 1'b1;
        in0_data  = 33'hC;
        for (int i = 0; i < 3; i++) begin
            check_bit("full_in0_ready", in0_ready, 1'b0);
            check_bit("full_in1_ready", in1_ready, 1'b0);
            check_bit("full_sel_held", sel_ready, 1'b0);
            check("full_head_stable", out_data, 33'hA);
            tick();
        end
        out_ready = 1'b1;
        wait_in_ready(1'b0);
        tick();
        exp_q.push_back(33'hC);
        in0_valid = 1'b0;
        drain();

        // 5. Random grants, gaps and downstream back-pressure against the queue.
        hit_full   = 1'b0;
        hit_empty  = 1'b0;
        rand_ready = 1'b1;
        lo_phase   = 1'b1;
        for (int i = 0; i < 30; i++) begin
            pkt_t d;
            if (i == 15) lo_phase = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            d = {1'($urandom_range(0, 1)), $urandom};
            send(1'($urandom_range(0, 1)), d, $urandom_range(0, 2));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();
        check_bit("rand_hit_full", hit_full, 1'b1);
        check_bit("rand_hit_empty", hit_empty, 1'b1);

        // 6. Reset while waiting for data with two packets buffered.
        out_ready = 1'b0;
        send(1'b0, 33'h11, 0);
        send(1'b1, 33'h22, 0);
        sel_valid = 1'b1;
        sel_data  = 1'b1;
        tick();
        sel_valid = 1'b0;
        check_bit("pre_rst_sel_ready", sel_ready, 1'b0);
        check_bit("pre_rst_in1_ready", in1_ready, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_bit("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_data", out_data, '0);
        check_bit("mid_rst_sel_ready", sel_ready, 1'b1);
        check_bit("mid_rst_in0_ready", in0_ready, 1'b0);
        check_bit("mid_rst_in1_ready", in1_ready, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        send(1'b0, 33'h1_2345_6789, 1);
        drain();
        check_bit("post_rst_idle", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_grant_merge
